// File: rtl/noc_pkg.sv
// Shared NoC definitions: direction codes, coordinate width and packet field offsets.
package noc_pkg;

  typedef enum logic [2:0] {
    CIMA     = 3'b000,
    BAIXO    = 3'b001,
    ESQUERDA = 3'b010,
    DIREITA  = 3'b011,
    LOCAL    = 3'b100,
    INVALIDO = 3'b111
  } direcao_t;

  localparam int unsigned LARGURA_COORD = 2;

  // Packet layout, MSB first: pronto, x_destino, y_destino, payload.
  function automatic int unsigned bit_pronto(input int unsigned largura_dados);
    return largura_dados + 4;
  endfunction

  function automatic int unsigned bit_x_msb(input int unsigned largura_dados);
    return largura_dados + 3;
  endfunction

  function automatic int unsigned bit_y_msb(input int unsigned largura_dados);
    return largura_dados + 1;
  endfunction

endpackage

// File: rtl/memoria_fila.sv
// Packet storage for fila_entrada: synchronous write port, asynchronous read port.
module memoria_fila #(
  parameter int unsigned PROFUNDIDADE = 4,
  parameter int unsigned LARGURA      = 13,
  localparam int unsigned LARGURA_PTR = $clog2(PROFUNDIDADE)
) (
  input  logic                   clk,
  input  logic                   escreve,
  input  logic [LARGURA_PTR-1:0] end_escrita,
  input  logic [LARGURA-1:0]     dado_escrita,
  input  logic [LARGURA_PTR-1:0] end_leitura,
  output logic [LARGURA-1:0]     dado_leitura
);

  logic [LARGURA-1:0] mem_q [PROFUNDIDADE];

  always_ff @(posedge clk) begin
    if (escreve) begin
      mem_q[end_escrita] <= dado_escrita;
    end
  end

  assign dado_leitura = mem_q[end_leitura];

endmodule

// File: rtl/fila_entrada.sv
// Per-port input FIFO of the XY-mesh router; first-word fall-through head for direcao_xy.
// Optional drop counter on port descartes when FILA_CONTA_DESCARTE_EN is defined.
module fila_entrada
  import noc_pkg::*;
#(
  parameter int unsigned LARGURA_DADOS  = 8,
  parameter int unsigned PROFUNDIDADE   = 4,
  localparam int unsigned LARGURA_PACOTE = LARGURA_DADOS + 5,
  localparam int unsigned LARGURA_PTR    = $clog2(PROFUNDIDADE),
  localparam int unsigned LARGURA_OCUP   = $clog2(PROFUNDIDADE) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LARGURA_PACOTE-1:0] pacote_in,
  input  logic                      valido_in,
  output logic                      aceita,
  input  logic                      le,
  output logic [LARGURA_COORD-1:0]  x_destino,
  output logic [LARGURA_COORD-1:0]  y_destino,
  output logic                      pronto,
  output logic [LARGURA_DADOS-1:0]  dados,
  output logic                      empty,
  output logic                      full,
`ifdef FILA_CONTA_DESCARTE_EN
  output logic [7:0]                descartes,
`endif
  output logic [LARGURA_OCUP-1:0]   ocupacao
);

  localparam int unsigned BIT_PRONTO = bit_pronto(LARGURA_DADOS);
  localparam int unsigned BIT_X_MSB  = bit_x_msb(LARGURA_DADOS);
  localparam int unsigned BIT_Y_MSB  = bit_y_msb(LARGURA_DADOS);

  logic [LARGURA_PTR-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LARGURA_PTR-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LARGURA_OCUP-1:0]   ocup_q, ocup_d;
  logic                      empty_q, full_q;
  logic                      escreve, retira;
  logic [LARGURA_PACOTE-1:0] pacote_cabeca;

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign aceita  = !rst && (!full_q || le);
  assign escreve = valido_in && aceita;
  assign retira  = le && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ocup_d   = ocup_q;
    if (escreve) begin
      wr_ptr_d = wr_ptr_q + LARGURA_PTR'(1);
    end
    if (retira) begin
      rd_ptr_d = rd_ptr_q + LARGURA_PTR'(1);
    end
    if (escreve && !retira) begin
      ocup_d = ocup_q + LARGURA_OCUP'(1);
    end else if (retira && !escreve) begin
      ocup_d = ocup_q - LARGURA_OCUP'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ocup_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ocup_q   <= ocup_d;
      empty_q  <= (ocup_d == '0);
      full_q   <= (ocup_d == LARGURA_OCUP'(PROFUNDIDADE));
    end
  end

  memoria_fila #(
    .PROFUNDIDADE (PROFUNDIDADE),
    .LARGURA      (LARGURA_PACOTE)
  ) u_memoria (
    .clk          (clk),
    .escreve      (escreve),
    .end_escrita  (wr_ptr_q),
    .dado_escrita (pacote_in),
    .end_leitura  (rd_ptr_q),
    .dado_leitura (pacote_cabeca)
  );

  // Zeroed head while empty so direcao_xy sees a clean idle pattern.
  always_comb begin
    x_destino = '0;
    y_destino = '0;
    pronto    = 1'b0;
    dados     = '0;
    if (!empty_q) begin
      pronto    = pacote_cabeca[BIT_PRONTO];
      x_destino = pacote_cabeca[BIT_X_MSB -: LARGURA_COORD];
      y_destino = pacote_cabeca[BIT_Y_MSB -: LARGURA_COORD];
      dados     = pacote_cabeca[LARGURA_DADOS-1:0];
    end
  end

  assign empty    = empty_q;
  assign full     = full_q;
  assign ocupacao = ocup_q;

`ifdef FILA_CONTA_DESCARTE_EN
  logic [7:0] descartes_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      descartes_q <= '0;
    end else if (valido_in && !aceita && (descartes_q != 8'hFF)) begin
      descartes_q <= descartes_q + 8'd1;
    end
  end

  assign descartes = descartes_q;
`endif

endmodule

// File: tb/tb_fila_entrada.sv
// Self-checking bench for fila_entrada: queue-based reference model plus directed corner cases.
module tb_fila_entrada;

  localparam int unsigned LD   = 8;
  localparam int unsigned PROF = 4;
  localparam int unsigned LP   = LD + 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [LP-1:0] pacote_in;
  logic          valido_in;
  logic          aceita;
  logic          le;
  logic [1:0]    x_destino, y_destino;
  logic          pronto;
  logic [LD-1:0] dados;
  logic          empty, full;
  logic [2:0]    ocupacao;
`ifdef FILA_CONTA_DESCARTE_EN
  logic [7:0]    descartes;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [LP-1:0] fila_m[$];
  int            desc_m = 0;

  fila_entrada #(
    .LARGURA_DADOS (LD),
    .PROFUNDIDADE  (PROF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pacote_in (pacote_in),
    .valido_in (valido_in),
    .aceita    (aceita),
    .le        (le),
    .x_destino (x_destino),
    .y_destino (y_destino),
    .pronto    (pronto),
    .dados     (dados),
    .empty     (empty),
    .full      (full),
`ifdef FILA_CONTA_DESCARTE_EN
    .descartes (descartes),
`endif
    .ocupacao  (ocupacao)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [LP-1:0] mk(input logic p, input logic [1:0] x, input logic [1:0] y,
                                       input logic [7:0] d);
    return {p, x, y, d};
  endfunction

  // One cycle: drive at negedge, compare against the model, then advance the model at posedge.
  task automatic step(input logic [LP-1:0] p, input logic v, input logic l, input logic r);
    logic          exp_acc;
    logic [LP-1:0] exp_head;
    int            n;
    @(negedge clk);
    pacote_in = p;
    valido_in = v;
    le        = l;
    rst       = r;
    #1;
    n        = fila_m.size();
    exp_acc  = !r && ((n < PROF) || l);
    exp_head = (n > 0) ? fila_m[0] : '0;
    check_eq("aceita", aceita, exp_acc);
    check_eq("empty", empty, n == 0);
    check_eq("full", full, n == PROF);
    check_eq("ocupacao", ocupacao, n);
    check_eq("cabeca", {pronto, x_destino, y_destino, dados}, exp_head);
`ifdef FILA_CONTA_DESCARTE_EN
    check_eq("descartes", descartes, desc_m);
`endif
    @(posedge clk);
    if (r) begin
      fila_m.delete();
      desc_m = 0;
    end else begin
      if (l && n > 0) void'(fila_m.pop_front());
      if (v && exp_acc) fila_m.push_back(p);
      if (v && !exp_acc && desc_m < 255) desc_m++;
    end
  endtask

  initial begin
    pacote_in = '0;
    valido_in = 1'b0;
    le        = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Idle after reset.
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_ocup", ocupacao, 0);
    check_eq("rst_cabeca", {pronto, x_destino, y_destino, dados}, 0);
    step('0, 1'b0, 1'b0, 1'b0);
    check_eq("idle_aceita", aceita, 1);

    // Single packet.
    step(mk(1'b0, 2'd2, 2'd1, 8'hA5), 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("um_empty", empty, 0);
    check_eq("um_x", x_destino, 2);
    check_eq("um_y", y_destino, 1);
    check_eq("um_pronto", pronto, 0);
    check_eq("um_dados", dados, 8'hA5);
    check_eq("um_ocup", ocupacao, 1);
    step('0, 1'b0, 1'b1, 1'b0);
    #1;
    check_eq("um_pop_empty", empty, 1);

    // Fill, reject the 5th, drain in order.
    for (int i = 1; i <= 4; i++) step(mk(i[0], 2'd3, 2'd0, 8'(i)), 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("cheia_full", full, 1);
    check_eq("cheia_aceita", aceita, 0);
    step(mk(1'b1, 2'd1, 2'd1, 8'h05), 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      #1;
      check_eq("drena_dados", dados, i);
      step('0, 1'b0, 1'b1, 1'b0);
    end
    #1;
    check_eq("drena_empty", empty, 1);

    // Full with simultaneous pop and push.
    for (int i = 1; i <= 4; i++) step(mk(1'b0, 2'd0, 2'd3, 8'(i)), 1'b1, 1'b0, 1'b0);
    step(mk(1'b1, 2'd1, 2'd2, 8'h99), 1'b1, 1'b1, 1'b0);
    #1;
    check_eq("pp_ocup", ocupacao, 4);
    check_eq("pp_cabeca", dados, 8'h02);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("pp_ordem", dados, (i == 3) ? 8'h99 : 8'(i + 2));
      step('0, 1'b0, 1'b1, 1'b0);
    end

    // Continuous write+pop at occupancy 1, across pointer wrap.
    step(mk(1'b0, 2'd1, 2'd1, 8'h10), 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(mk(1'b0, 2'd1, 2'd1, 8'(8'h10 + i)), 1'b1, 1'b1, 1'b0);
      #1;
      check_eq("wrap_ocup", ocupacao, 1);
      check_eq("wrap_dados", dados, 8'h10 + i);
    end
    step('0, 1'b0, 1'b1, 1'b0);

    // Pop on empty is ignored; write+pop on empty stores the write.
    step('0, 1'b0, 1'b1, 1'b0);
    #1;
    check_eq("le_vazia_ocup", ocupacao, 0);
    step(mk(1'b1, 2'd3, 2'd3, 8'h3C), 1'b1, 1'b1, 1'b0);
    #1;
    check_eq("wp_vazia_ocup", ocupacao, 1);
    check_eq("wp_vazia_dados", dados, 8'h3C);

    // Reset mid-operation at occupancy 3.
    step(mk(1'b0, 2'd0, 2'd0, 8'h41), 1'b1, 1'b0, 1'b0);
    step(mk(1'b0, 2'd0, 2'd0, 8'h42), 1'b1, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b1);
    #1;
    check_eq("rst3_empty", empty, 1);
    check_eq("rst3_ocup", ocupacao, 0);

`ifdef FILA_CONTA_DESCARTE_EN
    for (int i = 0; i < 4; i++) step(mk(1'b0, 2'd1, 2'd2, 8'(i)), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(mk(1'b1, 2'd2, 2'd2, 8'hEE), 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("desc_sat", descartes, 255);
    step('0, 1'b0, 1'b0, 1'b1);
    #1;
    check_eq("desc_rst", descartes, 0);
`endif

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      step(LP'($urandom), ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < 2);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fila_entrada.md
Name: fila_entrada

Overview:
- Input FIFO for one router port of the 4x4 XY-mesh NoC; one instance per port (CIMA, BAIXO, ESQUERDA, DIREITA, LOCAL).
- Buffers incoming packets and exposes the head packet's destination fields, its processed bit and the empty flag.
- These outputs drive direcao_xy directly.
- The crossbar/arbiter pops the head when it grants the output that direcao_xy selected.

Parameters:
- LARGURA_DADOS, 8, payload width in bits.
- PROFUNDIDADE, 4, number of packet slots; power of two, minimum 2.
- LARGURA_PACOTE, LARGURA_DADOS+5, derived; not to be overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pacote_in  input  LARGURA_PACOTE  incoming packet. Layout: [LARGURA_PACOTE-1] pronto, [LARGURA_PACOTE-2:LARGURA_PACOTE-3] x_destino, [LARGURA_PACOTE-4:LARGURA_PACOTE-5] y_destino, [LARGURA_DADOS-1:0] payload.
- valido_in  input  1  upstream offers pacote_in this cycle.
- aceita  output  1  FIFO accepts a packet this cycle.
- le  input  1  pop request from the crossbar/arbiter.
- x_destino  output  2  head packet X destination.
- y_destino  output  2  head packet Y destination.
- pronto  output  1  head packet processed bit.
- dados  output  LARGURA_DADOS  head payload.
- empty  output  1  FIFO holds no packet.
- full  output  1  FIFO holds PROFUNDIDADE packets.
- ocupacao  output  $clog2(PROFUNDIDADE)+1  current packet count.

Behaviour:
- Reset (rst=1 at an edge):
  - Read and write pointers = 0, ocupacao = 0, empty = 1, full = 0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all buffered packets.
  - aceita is 0 while rst is high.
- Accept rule: aceita = !rst && (!full || le).
  - A full FIFO still accepts a packet in the same cycle it is popped.
  - Write occurs when valido_in && aceita; the packet is stored at wr_ptr, and wr_ptr increments modulo PROFUNDIDADE.
- Pop rule: a pop occurs when le && !empty; rd_ptr increments modulo PROFUNDIDADE.
  - le while empty is ignored: no pointer change and no error.
- Occupancy update:
  - Write only: ocupacao +1.
  - Pop only: ocupacao -1.
  - Both, or neither: unchanged.
- Flags are registered, derived from the next ocupacao: empty = (ocupacao==0), full = (ocupacao==PROFUNDIDADE).
- Head outputs are first-word fall-through, read combinationally from slot rd_ptr.
  - A packet written into an empty FIFO at edge N appears on the head outputs, with empty=0, after edge N.
  - Write-to-head latency is 1 cycle.
- While empty=1, x_destino, y_destino, pronto and dados are forced to 0. direcao_xy then emits its invalid code 3'b111 from empty.
- Simultaneous write+pop on an empty FIFO: the pop is ignored and the write proceeds (ocupacao 0->1).
- Pointer wrap is implicit modulo PROFUNDIDADE; no bubble at wrap.
- Packets leave in arrival order; the FIFO never modifies packet contents, including the pronto bit.

Optional Feature:
- Macro: FILA_CONTA_DESCARTE_EN.
- Defined:
  - Adds output port descartes, 8 bits.
  - descartes counts cycles with valido_in=1 && aceita=0, excluding cycles with rst=1.
  - Saturates at 255; reset to 0 by rst.
- Undefined: the port and its logic are absent, and the remaining behaviour is identical.

Decomposition:
- Package noc_pkg holds:
  - Direction codes CIMA=3'b000, BAIXO=3'b001, ESQUERDA=3'b010, DIREITA=3'b011, LOCAL=3'b100, INVALIDO=3'b111.
  - Packet field bit offsets as functions of LARGURA_DADOS.
  - Coordinate width (2).
- Sub-module memoria_fila: PROFUNDIDADE x LARGURA_PACOTE register array with synchronous write port and asynchronous read port.
  - fila_entrada owns the pointers, counter, flags and handshake.

Test Plan:
- Reset then idle: after rst=1 for 2 cycles -> empty=1, full=0, ocupacao=0, aceita=1, x_destino=y_destino=pronto=dados=0.
- Single packet: write pacote_in={1'b0,2'd2,2'd1,8'hA5} with valido_in=1 for 1 cycle.
  - Next cycle: empty=0, x_destino=2, y_destino=1, pronto=0, dados=8'hA5, ocupacao=1.
  - le=1 for 1 cycle -> empty=1.
- Fill, then drain, in order: write 4 packets with payloads 8'h01..8'h04 -> full=1, aceita=0.
  - A 5th packet (8'h05) with valido_in=1 and le=0 is not stored.
  - Draining yields dados 01,02,03,04 in order.
- Full with simultaneous pop+push: full FIFO, le=1 and valido_in=1 with 8'h99 -> aceita=1, ocupacao stays 4.
  - The head advances; 8'h99 is popped last, after the 3 older packets.
- Wrap-around and corner cases:
  - 10 cycles of continuous write+pop at ocupacao=1 -> no loss or duplication, and ocupacao stays 1 throughout.
  - le=1 on an empty FIFO -> no change.
  - rst=1 with ocupacao=3 -> next cycle empty=1.
- FILA_CONTA_DESCARTE_EN: full FIFO with valido_in=1, le=0 for 300 cycles -> descartes=255 (saturated); then rst -> descartes=0.
